drv_ps2_keyboard_evt: RTL
=========================

DRV_PS2_KEYBOARD_EVT -- requirements
Module: drv_ps2_keyboard_evt

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning event FIFO entries; power of two, range 2..64.
REQ-002 The block SHALL have parameter TIMEOUT, default 1_000_000, meaning the maximum i_clk cycles between bytes of one multi-byte sequence; range 2..2^24-1.
REQ-003 The block SHALL have parameter REPEAT_FILTER, default 1, meaning 1 suppresses typematic repeats and 0 passes them.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: synchronous, active-low reset; i_rst=0 at a rising i_clk edge resets.
REQ-006 The block SHALL have port i_dat, input, 8 bits: received PS/2 byte.
REQ-007 The block SHALL have port i_emp, input, 1 bit: byte-stream empty flag; i_emp=0 marks i_dat valid for exactly that cycle (one byte per low cycle).
REQ-008 The block SHALL have port o_valid, output, 1 bit: FIFO head event available.
REQ-009 The block SHALL have port i_ready, input, 1 bit: consumer accepts head; pop when o_valid & i_ready.
REQ-010 The block SHALL have port o_key, output, 16 bits: head key code; [15:8]=prefix (00, E0 or E1), [7:0]=code.
REQ-011 The block SHALL have port o_release, output, 1 bit: head event is a break (1) or make (0).
REQ-012 The block SHALL have port o_count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-013 The block SHALL have port o_ovf, output, 1 bit: sticky flag, an event was dropped on FIFO full.
REQ-014 The block SHALL have port o_err, output, 1 bit: 1-cycle pulse on timeout abort or keyboard error byte.

Function
REQ-015 The decoder SHALL be a state machine with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and PAUSE (after E1).
REQ-016 In IDLE, byte E0 SHALL go to EXT, F0 to BRK and E1 to PAUSE with the skip counter set to 7; any other code byte SHALL emit {00,byte} as a make and stay in IDLE.
REQ-017 In EXT, F0 SHALL go to EXT_BRK, and any other byte SHALL emit {E0,byte} as a make and return to IDLE.
REQ-018 In BRK, a byte SHALL emit {00,byte} as a break; in EXT_BRK, a byte SHALL emit {E0,byte} as a break; both SHALL return to IDLE.
REQ-019 PAUSE SHALL consume 7 further bytes unchecked, then emit {E1,77} as a make and return to IDLE; no break SHALL be emitted for Pause.
REQ-020 Control bytes FA (ack), AA (BAT ok) and EE (echo) SHALL be discarded in IDLE without state change or event.
REQ-021 Bytes 00, FF, FC and FD in any state SHALL pulse o_err, emit no event and force IDLE.
REQ-022 A timeout counter SHALL reload on each accepted byte; if it reaches TIMEOUT while the state is not IDLE, the machine SHALL pulse o_err and return to IDLE with nothing emitted.
REQ-023 When REPEAT_FILTER=1, a make equal to the last emitted make, with no break emitted since, SHALL be suppressed; any break SHALL clear the last-make register.
REQ-024 An emitted event SHALL be written to the FIFO on the cycle after its final byte is accepted, and o_valid SHALL rise on the following cycle when the FIFO was empty (2-cycle byte-to-valid latency).
REQ-025 o_key and o_release SHALL reflect the FIFO head whenever o_valid=1, and SHALL be held stable while o_valid=1 and i_ready=0.
REQ-026 On a write while full without a simultaneous pop, the event SHALL be dropped, o_ovf SHALL be set, and the FIFO contents SHALL be unchanged.
REQ-027 A simultaneous write and pop SHALL both take effect, including when full, and o_count SHALL be unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL be the exact occupancy, 0..DEPTH.
REQ-029 A pop with o_valid=0 SHALL be ignored.

Reset
REQ-030 With i_rst=0, the next edge SHALL force state IDLE, FIFO empty, pointers 0, last-make cleared and timeout counter 0.
REQ-031 Under reset, the outputs SHALL be o_valid=0, o_key=0000, o_release=0, o_count=0, o_ovf=0 and o_err=0.
REQ-032 Reset asserted mid-sequence (for example after E0) SHALL discard the partial sequence, and the next byte SHALL decode from IDLE.

Verification
REQ-033 Scenario: bytes 1C, F0 1C with i_ready=1 -> events {001C,make}, then {001C,break}; o_err=0.
REQ-034 Scenario: bytes E0 75, E0 F0 75 -> events {E075,make} and {E075,break}.
REQ-035 Scenario: bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E177,make}.
REQ-036 Scenario: REPEAT_FILTER=1, bytes 1C 1C 1C F0 1C 1C -> events 001C make, 001C break, 001C make (3 events).
REQ-037 Scenario: DEPTH=4, i_ready=0, 5 makes -> o_count=4, o_ovf=1, and the first 4 codes are read out in order.
REQ-038 Scenario: E0, then TIMEOUT idle cycles, then 1C -> one o_err pulse, then event {001C,make}.

Source files
------------

// File: rtl/drv_ps2_keyboard_evt_if.sv
// Byte-stream input and key-event output bundle for the PS/2 keyboard event decoder.
interface drv_ps2_keyboard_evt_if #(
   parameter int unsigned DEPTH = 8
);
   logic [7:0]              i_dat;
   logic                    i_emp;
   logic                    i_ready;
   logic                    o_valid;
   logic [15:0]             o_key;
   logic                    o_release;
   logic [$clog2(DEPTH):0]  o_count;
   logic                    o_ovf;
   logic                    o_err;

   // Byte producer / event consumer side
   modport master (
      output i_dat, i_emp, i_ready,
      input  o_valid, o_key, o_release, o_count, o_ovf, o_err
   );

   // Decoder side
   modport slave (
      input  i_dat, i_emp, i_ready,
      output o_valid, o_key, o_release, o_count, o_ovf, o_err
   );
endinterface

// File: rtl/drv_ps2_keyboard_evt.sv
// PS/2 set-2 scan-code decoder: turns a received byte stream into make/break
// key events, filters typematic repeats and queues events in a small FIFO.
module drv_ps2_keyboard_evt #(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned TIMEOUT       = 1_000_000,
   parameter bit          REPEAT_FILTER = 1'b1
) (
   input logic                   i_clk,
   input logic                   i_rst,
   drv_ps2_keyboard_evt_if.slave bus
);
   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [23:0]   TMO_LAST = 24'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

   state_t        state_q;
   logic [2:0]    skip_q;
   logic [23:0]   tmo_q;
   logic          lm_vld_q;
   logic [15:0]   lm_key_q;
   logic          ev_vld_q;
   logic [15:0]   ev_key_q;
   logic          ev_rel_q;
   logic          err_q;

   logic [16:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q;

   logic [7:0]    dat;
   logic          acc;
   logic          is_err;
   logic          is_pfx;
   logic          is_ctl;
   logic          cand_vld;
   logic          emit_d;
   logic [15:0]   ev_key_d;
   logic          ev_rel_d;
   logic          valid;
   logic          pop;
   logic          wr_ok;

   assign dat    = bus.i_dat;
   assign acc    = ~bus.i_emp;
   assign is_err = (dat == 8'h00) || (dat == 8'hFF) || (dat == 8'hFC) || (dat == 8'hFD);
   assign is_pfx = (dat == 8'hE0) || (dat == 8'hF0) || (dat == 8'hE1);
   assign is_ctl = (dat == 8'hFA) || (dat == 8'hAA) || (dat == 8'hEE);

   // Candidate event for the byte being accepted, then the repeat filter
   always_comb begin
      cand_vld = 1'b0;
      ev_key_d = '0;
      ev_rel_d = 1'b0;
      case (state_q)
         IDLE: begin
            cand_vld = !is_pfx && !is_ctl;
            ev_key_d = {8'h00, dat};
         end
         EXT: begin
            cand_vld = (dat != 8'hF0);
            ev_key_d = {8'hE0, dat};
         end
         BRK: begin
            cand_vld = 1'b1;
            ev_key_d = {8'h00, dat};
            ev_rel_d = 1'b1;
         end
         EXT_BRK: begin
            cand_vld = 1'b1;
            ev_key_d = {8'hE0, dat};
            ev_rel_d = 1'b1;
         end
         PAUSE: begin
            cand_vld = (skip_q == 3'd1);
            ev_key_d = 16'hE177;
         end
         default: cand_vld = 1'b0;
      endcase
      if (!acc || is_err)
         cand_vld = 1'b0;
      emit_d = cand_vld &&
               !(REPEAT_FILTER && !ev_rel_d && lm_vld_q && (lm_key_q == ev_key_d));
   end

   // Decoder state machine, inter-byte timeout, last-make tracking and event register
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         skip_q   <= '0;
         tmo_q    <= '0;
         lm_vld_q <= 1'b0;
         lm_key_q <= '0;
         ev_vld_q <= 1'b0;
         ev_key_q <= '0;
         ev_rel_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ev_vld_q <= emit_d;
         ev_key_q <= ev_key_d;
         ev_rel_q <= ev_rel_d;
         err_q    <= 1'b0;
         if (emit_d) begin
            if (ev_rel_d) begin
               lm_vld_q <= 1'b0;
            end else begin
               lm_vld_q <= 1'b1;
               lm_key_q <= ev_key_d;
            end
         end
         if (acc) begin
            tmo_q <= '0;
            if (is_err) begin
               err_q   <= 1'b1;
               state_q <= IDLE;
            end else begin
               case (state_q)
                  IDLE: begin
                     if (dat == 8'hE0) state_q <= EXT;
                     else if (dat == 8'hF0) state_q <= BRK;
                     else if (dat == 8'hE1) begin
                        state_q <= PAUSE;
                        skip_q  <= 3'd7;
                     end
                  end
                  EXT:          state_q <= (dat == 8'hF0) ? EXT_BRK : IDLE;
                  BRK, EXT_BRK: state_q <= IDLE;
                  PAUSE: begin
                     if (skip_q == 3'd1) state_q <= IDLE;
                     else skip_q <= skip_q - 3'd1;
                  end
                  default:      state_q <= IDLE;
               endcase
            end
         end else if (state_q != IDLE) begin
            if (tmo_q >= TMO_LAST) begin
               err_q   <= 1'b1;
               state_q <= IDLE;
               tmo_q   <= '0;
            end else begin
               tmo_q <= tmo_q + 24'd1;
            end
         end
      end
   end

   assign valid = (count_q != '0);
   assign pop   = valid && bus.i_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
   assign wr_ok = ev_vld_q && ((count_q != FULL_CNT) || pop);

   // Event storage; entries are only observed through the occupancy-gated head
   always_ff @(posedge i_clk) begin
      if (wr_ok)
         mem_q[wr_ptr_q] <= {ev_rel_q, ev_key_q};
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         if (ev_vld_q && !wr_ok) ovf_q <= 1'b1;
         case ({wr_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.o_valid   = valid;
   assign bus.o_key     = valid ? mem_q[rd_ptr_q][15:0] : '0;
   assign bus.o_release = valid ? mem_q[rd_ptr_q][16] : 1'b0;
   assign bus.o_count   = count_q;
   assign bus.o_ovf     = ovf_q;
   assign bus.o_err     = err_q;
endmodule
